// File: rtl/execute_and_branch.sv
// Execute stage: ALU/shifter, result select, branch resolution and the
// two-cycle kill of the younger instructions behind a taken branch.
//
// state | meaning
// IDLE  | no kill pending; flush follows branch_taken
// KILL  | branch was taken last cycle; keep killing decode for one more cycle
module execute_and_branch #(
  parameter int DATA_BITS      = 32,
  parameter int reg_addr_width = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_BITS-1:0]      pc_min_two,
  input  logic                      RW,
  input  logic                      MW,
  input  logic                      PS,
  input  logic [reg_addr_width-1:0] DA,
  input  logic [1:0]                MD,
  input  logic [1:0]                BS,
  input  logic [3:0]                FS,
  input  logic [reg_addr_width-1:0] SH,
  input  logic [DATA_BITS-1:0]      BUSA,
  input  logic [DATA_BITS-1:0]      BUSB,
  input  logic [DATA_BITS-1:0]      mem_rdata,
  output logic [DATA_BITS-1:0]      mem_addr,
  output logic [DATA_BITS-1:0]      mem_wdata,
  output logic                      mem_we,
  output logic                      RW_EXE,
  output logic [reg_addr_width-1:0] DA_EXE,
  output logic [DATA_BITS-1:0]      forward_data,
  output logic                      flush,
  output logic                      branch_taken,
  output logic [DATA_BITS-1:0]      branch_target,
  output logic                      RW_WB,
  output logic [reg_addr_width-1:0] DA_WB,
  output logic [DATA_BITS-1:0]      BUSD_WB,
  output logic [3:0]                status
);
  localparam int MSB = DATA_BITS - 1;

  typedef enum logic {IDLE, KILL} state_t;
  state_t state;

  logic [DATA_BITS-1:0] b_op;
  logic                 cin;
  logic [DATA_BITS:0]   sum;
  logic [DATA_BITS-1:0] f;
  logic [DATA_BITS-1:0] busd;
  logic                 arith, v, c, n, z;
  logic                 taken_raw;

  // All arithmetic codes share one adder: A + b_op + cin.
  always_comb begin
    b_op = '0;
    cin  = 1'b0;
    case (FS)
      4'b0001: cin = 1'b1;
      4'b0010: b_op = BUSB;
      4'b0011: begin b_op = BUSB;  cin = 1'b1; end
      4'b0100: b_op = ~BUSB;
      4'b0101: begin b_op = ~BUSB; cin = 1'b1; end
      4'b0110: b_op = '1;
      default: ;
    endcase
  end

  assign sum   = {1'b0, BUSA} + {1'b0, b_op} + {{DATA_BITS{1'b0}}, cin};
  assign arith = ~FS[3];

  always_comb begin
    f = '0;
    case (FS)
      4'b1000: f = BUSA & BUSB;
      4'b1001: f = BUSA | BUSB;
      4'b1010: f = BUSA ^ BUSB;
      4'b1011: f = ~BUSA;
      4'b1100: f = BUSB;
      4'b1101: f = BUSB >> SH;
      4'b1110: f = BUSB << SH;
      4'b1111: f = '0;
      default: f = sum[MSB:0];
    endcase
  end

  assign c = arith & sum[DATA_BITS];
  assign v = arith & (BUSA[MSB] == b_op[MSB]) & (f[MSB] != BUSA[MSB]);
  assign n = f[MSB];
  assign z = (f == '0);

  always_comb begin
    case (MD)
      2'b00:   busd = f;
      2'b01:   busd = mem_rdata;
      2'b10:   busd = {{(DATA_BITS-1){1'b0}}, n ^ v};
      default: busd = {{(DATA_BITS-1){1'b0}}, z};
    endcase
  end

  assign mem_addr     = BUSA;
  assign mem_wdata    = BUSB;
  assign mem_we       = MW & rst_n;
  assign RW_EXE       = RW & rst_n;
  assign DA_EXE       = DA;
  assign forward_data = busd;

  assign taken_raw     = (BS == 2'b01) ? (z ^ PS) : BS[1];
  assign branch_taken  = taken_raw & rst_n;
  assign branch_target = (BS == 2'b11) ? BUSA : (pc_min_two + BUSB);
  assign flush         = ~(branch_taken | (rst_n & (state == KILL)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      RW_WB   <= 1'b0;
      DA_WB   <= '0;
      BUSD_WB <= '0;
      status  <= 4'b0000;
    end else begin
      RW_WB   <= RW;
      DA_WB   <= DA;
      BUSD_WB <= busd;
      if (FS != 4'b1111) status <= {v, c, n, z};
      unique case (state)
        IDLE: if (branch_taken) state <= KILL;
        KILL: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/execute_and_branch.md
# execute_and_branch

Execute stage of the five-stage pipelined CPU, placed directly after the decode/operand-fetch stage. It consumes that stage's registered control word and operand buses and computes the ALU/shifter result. It drives the data memory and resolves branches and jumps toward instruction fetch. It returns the forwarding triple (`RW_EXE`, `DA_EXE`, `forward_data`) and the active-low `flush` to decode, and registers the write-back bundle.

## Interface
- DATA_BITS, 32, datapath width
- reg_addr_width, 5, register address / shift amount width
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  synchronous, active-low reset
- pc_min_two  input  DATA_BITS  PC of the instruction now in execute
- RW, MW, PS  input  1 each  register write, memory write, branch polarity
- DA  input  reg_addr_width  destination register
- MD, BS  input  2 each  result select, branch select
- FS  input  4  function select
- SH  input  reg_addr_width  shift amount
- BUSA, BUSB  input  DATA_BITS  operands (BUSB already muxed to immediate)
- mem_rdata  input  DATA_BITS  data memory read data, combinational read
- mem_addr, mem_wdata  output  DATA_BITS  BUSA and BUSB
- mem_we  output  1  data memory write enable
- RW_EXE  output  1  forwarding: execute writes a register
- DA_EXE  output  reg_addr_width  forwarding: destination
- forward_data  output  DATA_BITS  forwarding: execute result (BUSD)
- flush  output  1  active-low kill to decode
- branch_taken  output  1  instruction fetch loads branch_target
- branch_target  output  DATA_BITS  next PC when taken
- RW_WB  output  1  registered RW
- DA_WB  output  reg_addr_width  registered DA
- BUSD_WB  output  DATA_BITS  registered result
- status  output  4  registered {V,C,N,Z} of last arithmetic/logic op

## Operation
- FS codes, F = ALU result:
  - 0000 A; 0001 A+1; 0010 A+B; 0011 A+B+1
  - 0100 A+~B; 0101 A-B; 0110 A-1; 0111 A
  - 1000 A&B; 1001 A|B; 1010 A^B; 1011 ~A
  - 1100 B; 1101 B>>SH logical; 1110 B<<SH; 1111 yields 0
- Arithmetic is modulo 2^DATA_BITS.
- C is the carry out and V is the two's-complement overflow, valid for codes 0000-0111; C=V=0 otherwise.
- Z = (F==0), N = F[MSB].
- BUSD selection by MD:
  - 00: F
  - 01: mem_rdata
  - 10: {0…, N^V} (set-less-than)
  - 11: {0…, Z}
- Memory: mem_addr=BUSA, mem_wdata=BUSB, mem_we=MW.
- Forwarding outputs, all combinational: RW_EXE=RW, DA_EXE=DA, forward_data=BUSD.
- Branch control, with Z taken from the current F:
  - BS 00: not taken.
  - BS 01: taken iff Z^PS, so PS=0 branches on zero and PS=1 on nonzero; target = pc_min_two+BUSB.
  - BS 10: always taken; target pc_min_two+BUSB.
  - BS 11: always taken; target BUSA.
  - When not taken, branch_target = pc_min_two+BUSB (don't-care for fetch).
- Kill FSM, states IDLE/KILL:
  - IDLE→KILL on branch_taken.
  - KILL→IDLE unconditionally.
  - flush = ~(branch_taken | state==KILL), which kills the decode-stage instruction and the fetch-stage instruction behind the branch.
  - A killed instruction arrives with RW=MW=0 and BS=00, so KILL never sees a new taken branch.
- Status register loads {V,C,N,Z} every cycle in which FS≠1111.
- While rst_n=0:
  - mem_we, RW_EXE and branch_taken are forced 0 and flush is forced 1.
  - Rising edge with rst_n=0: state←IDLE, RW_WB←0, DA_WB←0, BUSD_WB←0, status←0.

## Timing
- F, BUSD, the forwarding outputs, the memory outputs, branch_taken and branch_target are combinational from the input registers: zero-cycle latency.
- Write-back registers update every edge: latency 1.
- Taken branch in cycle t: flush=0 in t and in t+1, flush=1 in t+2.
- Back-to-back taken branches are impossible because of the kill; no extension behaviour is defined for them.
- Reset mid-KILL: state→IDLE at that edge; flush=1 from the first cycle with rst_n=1.
- Reset values: flush=1, branch_taken=0, mem_we=0, RW_EXE=0, RW_WB=0, DA_WB=0, BUSD_WB=0, status=0.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with BS=10 and MW=1 -> flush=1, branch_taken=0, mem_we=0, all WB registers 0.
- Add with overflow: FS=0010, A=0x7FFFFFFF, B=1, MD=00, RW=1, DA=3 -> forward_data=0x80000000, RW_EXE=1, DA_EXE=3; next cycle BUSD_WB=0x80000000 and status={V=1,C=0,N=1,Z=0}.
- Shift and compare: FS=1110, B=0x1, SH=31 -> F=0x80000000. FS=0101, A=2, B=5, MD=10 -> BUSD=1.
- Conditional branch: FS=0000, A=0, BS=01, PS=0, pc_min_two=0x100, BUSB=0x10 -> branch_taken=1, target 0x110, flush low for exactly 2 cycles. Repeat with PS=1 -> not taken, flush stays 1.
- Jump register: BS=11, BUSA=0x4000 -> target 0x4000. Reset asserted the cycle after -> flush=1 from the first post-reset cycle.
- Memory: MW=1, BUSA=0x20, BUSB=0xDEAD -> mem_we=1, mem_addr=0x20. MD=01, mem_rdata=0xBEEF -> forward_data=0xBEEF and BUSD_WB=0xBEEF next cycle.
